// File: rtl/uart_pkg.sv
// Shared UART definitions: autobaud states and
// sync-character framing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_IDLE,
        WAIT_START,
        MEASURE
    } autobaud_state_t;

    localparam logic [7:0] AUTOBAUD_SYNC_CHAR = 8'h55;
    localparam int AUTOBAUD_TOL_SHIFT = 2;
    localparam int AUTOBAUD_EDGES = 9;

endpackage

// File: rtl/uart_autobaud_if.sv
// Control/result bundle between the autobaud
// detector and whoever arms it and consumes CLK_DIV.
interface uart_autobaud_if #(
    parameter int CNT_W = 32
);

    logic             start_i;
    logic [CNT_W-1:0] clk_div_o;
    logic             valid_o;
    logic             err_o;
    logic             busy_o;

    modport master (
        output start_i,
        input  clk_div_o,
        input  valid_o,
        input  err_o,
        input  busy_o
    );

    modport slave (
        input  start_i,
        output clk_div_o,
        output valid_o,
        output err_o,
        output busy_o
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the UART rx pin with
// rise/fall pulses; idles high out of reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rstn_i,
    input  logic rx_i,
    output logic rx_s,
    output logic rise,
    output logic fall
);

    logic rx_q1;
    logic rx_prev;

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            rx_q1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_q1   <= rx_i;
            rx_s    <= rx_q1;
            rx_prev <= rx_s;
        end
    end

    assign rise = rx_s & ~rx_prev;
    assign fall = ~rx_s & rx_prev;

endmodule

// File: rtl/uart_autobaud.sv
// Measures the bit period of a 0x55 sync character and
// produces a CLK_DIV value (clk cycles per bit).
module uart_autobaud
    import uart_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int MIN_BIT = 16
) (
    input  logic            clk,
    input  logic            rstn_i,
    input  logic            rx_i,
    uart_autobaud_if.slave  ab
);

    localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_BIT);
    localparam int TW = CNT_W + 3;

    logic rx_s;
    logic rise;
    logic fall;
    logic edge_s;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rstn_i (rstn_i),
        .rx_i   (rx_i),
        .rx_s   (rx_s),
        .rise   (rise),
        .fall   (fall)
    );

    assign edge_s = rise | fall;

    autobaud_state_t state_q, state_d;

    logic [CNT_W-1:0] idle_q, idle_d;
    logic [CNT_W-1:0] seg_q, seg_d;
    logic [TW-1:0]    tot_q, tot_d;
    logic [CNT_W-1:0] l0_q, l0_d;
    logic [TW-1:0]    t_q, t_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] seg_inc;
    logic [TW-1:0]    tot_inc;
    logic [CNT_W-1:0] diff;
    logic [CNT_W-1:0] tol;
    logic [TW:0]      t_round;
    logic [CNT_W-1:0] div_res;
    logic             fail;
    logic             done;

    assign seg_inc = seg_q + 1'b1;
    assign tot_inc = tot_q + 1'b1;
    assign diff    = (seg_inc >= l0_q) ? seg_inc - l0_q
                                       : l0_q - seg_inc;
    assign tol     = l0_q >> AUTOBAUD_TOL_SHIFT;
    // Round-to-nearest of T/8; T spans exactly eight bit times.
    assign t_round = {1'b0, t_q} + (TW + 1)'(4);
    assign div_res = CNT_W'(t_round >> 3);

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            idle_q  <= '0;
            seg_q   <= '0;
            tot_q   <= '0;
            l0_q    <= '0;
            t_q     <= '0;
            idx_q   <= '0;
            div_q   <= '1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            seg_q   <= seg_d;
            tot_q   <= tot_d;
            l0_q    <= l0_d;
            t_q     <= t_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        seg_d   = seg_q;
        tot_d   = tot_q;
        l0_d    = l0_q;
        t_d     = t_q;
        idx_d   = idx_q;
        div_d   = div_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        fail    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ab.start_i) begin
                    state_d = WAIT_IDLE;
                    idle_d  = '0;
                end
            end
            WAIT_IDLE: begin
                if (!rx_s) begin
                    idle_d = '0;
                end else if (idle_q == MIN_W - 1'b1) begin
                    state_d = WAIT_START;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            WAIT_START: begin
                if (fall) begin
                    state_d = MEASURE;
                    seg_d   = '0;
                    tot_d   = '0;
                    idx_d   = '0;
                end
            end
            MEASURE: begin
                seg_d = seg_inc;
                tot_d = tot_inc;
                if ((&seg_q) || (&tot_q)) begin
                    fail = 1'b1;
                end else if (edge_s) begin
                    seg_d = '0;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == 4'd0) begin
                        l0_d = seg_inc;
                        fail = (seg_inc < MIN_W);
                    end else begin
                        fail = (diff > tol);
                    end
                    if (idx_q == 4'(AUTOBAUD_EDGES - 2)) begin
                        t_d = tot_inc;
                    end
                    if (idx_q == 4'(AUTOBAUD_EDGES - 1) && !fail) begin
                        if (div_res < MIN_W) begin
                            fail = 1'b1;
                        end else begin
                            done = 1'b1;
                        end
                    end
                end
                if (fail) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (done) begin
                    valid_d = 1'b1;
                    div_d   = div_res;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ab.clk_div_o = div_q;
    assign ab.valid_o   = valid_q;
    assign ab.err_o     = err_q;
    assign ab.busy_o    = (state_q != IDLE);

endmodule

// File: doc/uart_autobaud.md
# uart_autobaud

Automatic baud-rate detector on the UART receive pin. Once armed, it measures the bit period of a 0x55 sync character (8N1, LSB first) arriving on `rx_i`. It then produces a clock-divider value in the same encoding as the UART `CLK_DIV` register: clk cycles per bit. The block sits upstream of the UART's divider register, in parallel with the receiver on the same pin; software or a small sequencer copies `clk_div_o` into `CLK_DIV` on `valid_o`.

## Interface
- `CNT_W`, 32, width of `clk_div_o` and of the per-segment counter
- `MIN_BIT`, 16, minimum accepted bit period in clk cycles; also the idle-high time required before arming completes
- `clk` in 1: the single clock
- `rstn_i` in 1: reset, synchronous, active-low
- `start_i` in 1: arm one measurement; sampled only in IDLE
- `rx_i` in 1: asynchronous UART line, idle high
- `clk_div_o` out CNT_W: last accepted bit period; reset value all ones
- `valid_o` out 1: one-cycle pulse when `clk_div_o` is updated; reset 0
- `err_o` out 1: one-cycle pulse when a measurement is rejected; reset 0
- `busy_o` out 1: high in every state except IDLE; reset 0

## Operation
- `rx_i` passes through a 2-flop synchronizer (`rx_s`, reset value 1). The edge detector compares `rx_s` with its previous value.
- Frame edges, counted after the start falling edge e0, are e1..e9 (rising, falling, and so on). e8 is the falling edge at the start of d7; e9 is the rising edge at the start of the stop bit. The interval e0→e8 spans exactly 8 bit times.
- State machine:
  - IDLE: `start_i`=1 → WAIT_IDLE. `rx_s` edges are ignored.
  - WAIT_IDLE: counts consecutive `rx_s`=1 cycles, restarting at 0 on a low. When the count reaches MIN_BIT → WAIT_START.
  - WAIT_START: falling edge → MEASURE. Clear both counters and set the edge index to 0.
  - MEASURE: the total counter (CNT_W+3 bits) and the segment counter (CNT_W bits) increment every cycle. Both saturate.
    - On each edge, the segment length is `seg`. The first edge (e1) latches `L0 = seg`.
    - Every later edge requires `|seg − L0| <= (L0 >> 2)`.
    - At e8, latch `T` = the total count.
    - At e9, with all checks passing, load `clk_div_o = (T + 4) >> 3`, truncated to CNT_W, pulse `valid_o`, and go to IDLE.
- Rejection: pulse `err_o`, leave `clk_div_o` unchanged, and go to IDLE (no re-arm) when any of the following holds:
  - a tolerance violation occurs;
  - either counter saturates;
  - `L0 < MIN_BIT`;
  - the result `< MIN_BIT`.
- `valid_o` and `err_o` are never high in the same cycle.
- `start_i` while `busy_o`=1 is ignored.

## Timing
- A `rx_i` transition in cycle n appears on `rx_s` in cycle n+2. The edge is detected combinationally in n+2. The synchronizer offset cancels in all measured intervals.
- The e9 edge detected in cycle m gives `valid_o`=1 and the new `clk_div_o` in cycle m+1. Errors follow the same timing: detected in cycle m, `err_o` in m+1.
- Reset asserted in any state, including mid-MEASURE: next cycle IDLE, `clk_div_o` = all ones, and all pulses and `busy_o` at 0.
- `start_i` in the same cycle as a `rx_s` edge: the block arms, and the edge is ignored. The WAIT_IDLE count starts the following cycle.

## Structure
- `uart_pkg` contains:
  - `autobaud_state_t` enum {IDLE, WAIT_IDLE, WAIT_START, MEASURE};
  - `AUTOBAUD_SYNC_CHAR = 8'h55`;
  - `AUTOBAUD_TOL_SHIFT = 2`;
  - `AUTOBAUD_EDGES = 9`.
- Sub-module `uart_rx_sync` holds the 2-flop synchronizer plus rise/fall edge pulses, reset to idle-high. It is reusable by the receiver.

## Test plan
- MIN_BIT=16: `start_i`, then 0x55 at 100 clk/bit → `valid_o` pulse 1 cycle after e9 is seen; `clk_div_o`=100; `busy_o` falls the same cycle.
- Bit widths alternating 100/101 clk → T=804 → `clk_div_o`=101 and no error.
- After a valid result of 100, send 0x53 at 100 clk/bit (a 200-cycle segment) → `err_o` pulse, `clk_div_o` stays 100.
- 0x55 at 8 clk/bit with MIN_BIT=16 → `err_o` at e1+1, no `valid_o`.
- `rx_i` held low after `start_i` → stays WAIT_IDLE with `busy_o`=1. Then send 0x55 at 50 clk/bit preceded by ≥16 idle cycles → `clk_div_o`=50.
- CNT_W=8, 300 clk/bit → segment counter saturates → `err_o`. Separately, reset mid-MEASURE → `clk_div_o`=8'hFF and `busy_o`=0 the next cycle.
